// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage and its watchdog.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_pkg;

  // Memory-stage FSM: IDLE accepts work, BUSY waits on the data memory
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Default number of BUSY cycles before an unacknowledged access is aborted
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  reg_idx_t;

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive BUSY cycles and flags when an access has waited too long.
// Latency: expired is combinational from the count; it rises in the TIMEOUT_CYCLES-th run cycle.
// Backpressure: none; the count holds once expired until clear.
module mem_watchdog
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt;

  // cnt holds the number of run cycles already completed
  assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count run cycles; restart whenever the owner leaves the waiting state
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-memory access at a time, forwards ALU results. Optional MEM_TIMEOUT_EN adds an access watchdog.
// Latency: non-memory ops 1 cycle; memory ops 2 cycles minimum (accept cycle + ack cycle), then wb_valid.
// Backpressure: stall is raised combinationally in the accept cycle and throughout BUSY; upstream holds EX outputs.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [31:0] alu_out,
  input  logic [3:0]  reg_dest_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_reg_dest,
  output logic        stall,
  output logic        err
);

  mem_state_t state, state_nxt;
  reg_idx_t   dest_q;

  logic is_mem;
  logic aligned;
  logic accept;
  logic illegal;
  logic fwd;
  logic done;
  logic timeout;
  logic abort;

  // Decode the EX request; only IDLE looks at EX, BUSY ignores the held inputs
  always_comb begin
    is_mem  = ex_mem_rd ^ ex_mem_wr;
    aligned = (mem_addr[1:0] == 2'b00);
    accept  = (state == IDLE) && ex_valid && is_mem && aligned;
    illegal = (state == IDLE) && ex_valid &&
              ((ex_mem_rd && ex_mem_wr) || (is_mem && !aligned));
    fwd     = (state == IDLE) && ex_valid && !ex_mem_rd && !ex_mem_wr;
    done    = (state == BUSY) && dmem_ack;
    abort   = (state == BUSY) && timeout && !dmem_ack;
  end

`ifdef MEM_TIMEOUT_EN
  mem_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .run     (state == BUSY),
    .clear   (state != BUSY),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state and stall; an ack in the same cycle as expiry completes normally
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          stall     = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (done || abort) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request registers double as the latched access; they only change on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dest_q     <= '0;
    end else if (accept) begin
      dmem_req   <= 1'b1;
      dmem_we    <= ex_mem_wr;
      dmem_addr  <= {mem_addr[31:2], 2'b00};
      dmem_wdata <= mem_data;
      dest_q     <= reg_dest_in;
    end else if (done || abort) begin
      dmem_req   <= 1'b0;
    end
  end

  // Writeback and error pulses; a store writes back its own data
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_reg_dest <= '0;
      err         <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= illegal || abort;
      if (fwd) begin
        wb_valid    <= 1'b1;
        wb_data     <= alu_out;
        wb_reg_dest <= reg_dest_in;
      end else if (done) begin
        wb_valid    <= 1'b1;
        wb_data     <= dmem_we ? dmem_wdata : dmem_rdata;
        wb_reg_dest <= dest_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected WB/err events, a monitor pops them.
// Latency: checks stall length and wb_valid timing per scenario.
// Backpressure: EX inputs are held while stall is high.
`timescale 1ns/1ps
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] alu_out;
  logic [3:0]  reg_dest_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [3:0]  wb_reg_dest;
  logic        stall;
  logic        err;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    logic [3:0]  dest;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  mem_stage #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_mem_rd   (ex_mem_rd),
    .ex_mem_wr   (ex_mem_wr),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .alu_out     (alu_out),
    .reg_dest_in (reg_dest_in),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_reg_dest (wb_reg_dest),
    .stall       (stall),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_wb(input logic [31:0] d, input logic [3:0] r);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    e.dest   = r;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    e.dest   = '0;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid  = 1'b0;
    ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0;
  endtask

  // One memory access; ack driven in BUSY cycle ack_cyc; exp_stalls and exp_wb are hand values
  task automatic mem_op(input string nm, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] dest, input int ack_cyc,
                        input logic [31:0] rdata, input int exp_stalls,
                        input logic [31:0] exp_wb);
    int stalls = 0;
    int unstable = 0;
    push_wb(exp_wb, dest);
    ex_valid = 1'b1; ex_mem_rd = rd; ex_mem_wr = wr;
    mem_addr = addr; mem_data = data; reg_dest_in = dest; alu_out = 32'hBAD0_0000;
    @(negedge clk);
    if (stall) stalls++;
    chk({nm, "_req_in_accept"}, 32'(dmem_req), 32'd0);
    step();
    for (int c = 1; c <= ack_cyc; c++) begin
      if (c == ack_cyc) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
      @(negedge clk);
      if (stall) stalls++;
      if (!dmem_req || dmem_addr !== addr || dmem_we !== wr || (wr && dmem_wdata !== data))
        unstable++;
      step();
    end
    dmem_ack = 1'b0;
    idle_inputs();
    chk({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    chk({nm, "_req_unstable"}, 32'(unstable), 32'd0);
    @(negedge clk);
    chk({nm, "_wb_valid"}, 32'(wb_valid), 32'd1);
    chk({nm, "_req_dropped"}, 32'(dmem_req), 32'd0);
    chk({nm, "_stall_after"}, 32'(stall), 32'd0);
  endtask

  // Scoreboard monitor: every wb_valid/err pulse must match the next expected event
  always @(negedge clk) begin
    if (wb_valid || err) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: wb_valid=%0b err=%0b wb_data=%h, expected no output",
                 wb_valid, err, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_err", 32'(err), 32'(mon_e.is_err));
        chk("sb_wb_valid", 32'(wb_valid), 32'(!mon_e.is_err));
        if (!mon_e.is_err) begin
          chk("sb_wb_data", wb_data, mon_e.data);
          chk("sb_wb_dest", 32'(wb_reg_dest), 32'(mon_e.dest));
        end
      end
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    mem_addr = '0; mem_data = '0; alu_out = '0; reg_dest_in = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    step();
    rst = 1'b0;

    // Load 0x100, ack in third BUSY cycle
    mem_op("load100", 1'b1, 1'b0, 32'h100, 32'h0, 4'd3, 3, 32'hDEADBEEF, 4, 32'hDEADBEEF);
    step();

    // Store 0x200, ack in first BUSY cycle
    mem_op("store200", 1'b0, 1'b1, 32'h200, 32'h12345678, 4'd6, 1, 32'hFFFF_FFFF, 2, 32'h12345678);
    step();

    // Two back-to-back ALU forwards then an idle cycle
    push_wb(32'h55, 4'd5);
    ex_valid = 1'b1; alu_out = 32'h55; reg_dest_in = 4'd5; mem_addr = 32'h3;
    @(negedge clk);
    chk("alu1_stall", 32'(stall), 32'd0);
    step();
    push_wb(32'hA5A5_0F0F, 4'd12);
    alu_out = 32'hA5A5_0F0F; reg_dest_in = 4'd12;
    @(negedge clk);
    chk("alu1_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu2_stall", 32'(stall), 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("alu2_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_req", 32'(dmem_req), 32'd0);
    step();
    @(negedge clk);
    chk("idle_wb_valid", 32'(wb_valid), 32'd0);
    step();

    // Misaligned load 0x101
    push_err();
    ex_valid = 1'b1; ex_mem_rd = 1'b1; mem_addr = 32'h101; reg_dest_in = 4'd2;
    @(negedge clk);
    chk("misal_stall", 32'(stall), 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("misal_err", 32'(err), 32'd1);
    chk("misal_req", 32'(dmem_req), 32'd0);
    chk("misal_wb_valid", 32'(wb_valid), 32'd0);
    step();
    @(negedge clk);
    chk("misal_err_pulse", 32'(err), 32'd0);
    step();

    // rd and wr both set, aligned address
    push_err();
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b1; mem_addr = 32'h300;
    @(negedge clk);
    chk("rdwr_stall", 32'(stall), 32'd0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("rdwr_err", 32'(err), 32'd1);
    chk("rdwr_req", 32'(dmem_req), 32'd0);
    step();

    // Stray ack while IDLE
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
    step();

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 BUSY cycles, then a late ack is ignored
    begin
      int bad = 0;
      push_err();
      ex_valid = 1'b1; ex_mem_rd = 1'b1; mem_addr = 32'h500; reg_dest_in = 4'd7;
      step();
      idle_inputs();
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (!dmem_req || !stall || err) bad++;
        step();
      end
      chk("to_busy_hold", 32'(bad), 32'd0);
      @(negedge clk);
      chk("to_err", 32'(err), 32'd1);
      chk("to_req", 32'(dmem_req), 32'd0);
      chk("to_stall", 32'(stall), 32'd0);
      step();
      dmem_ack = 1'b1; dmem_rdata = 32'h4444_4444;
      step();
      dmem_ack = 1'b0;
      @(negedge clk);
      chk("to_late_ack_wb", 32'(wb_valid), 32'd0);
      chk("to_late_ack_req", 32'(dmem_req), 32'd0);
      step();
    end
`else
    // Without the watchdog a slow memory is simply waited for
    mem_op("slow", 1'b1, 1'b0, 32'h600, 32'h0, 4'd4, 20, 32'h0BAD_F00D, 21, 32'h0BAD_F00D);
    step();
`endif

    // Reset in the middle of a store, ack in the cycle after reset
    ex_valid = 1'b1; ex_mem_wr = 1'b1; mem_addr = 32'h400; mem_data = 32'hCAFE_F00D;
    reg_dest_in = 4'd9;
    step();
    idle_inputs();
    @(negedge clk);
    chk("rstb_req", 32'(dmem_req), 32'd1);
    chk("rstb_wdata", dmem_wdata, 32'hCAFE_F00D);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("rstb_z_req", 32'(dmem_req), 32'd0);
    chk("rstb_z_we", 32'(dmem_we), 32'd0);
    chk("rstb_z_addr", dmem_addr, 32'd0);
    chk("rstb_z_wdata", dmem_wdata, 32'd0);
    chk("rstb_z_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstb_z_wb_data", wb_data, 32'd0);
    chk("rstb_z_wb_dest", 32'(wb_reg_dest), 32'd0);
    chk("rstb_z_err", 32'(err), 32'd0);
    chk("rstb_z_stall", 32'(stall), 32'd0);
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("rstb_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstb_ack_req", 32'(dmem_req), 32'd0);
    step();

    // Recovery after reset
    mem_op("load700", 1'b1, 1'b0, 32'h700, 32'h0, 4'd15, 2, 32'h8765_4321, 3, 32'h8765_4321);
    step();
    step();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, number of BUSY cycles without dmem_ack before an access is aborted (used only with MEM_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ex_valid  in  1  EX-stage result valid this cycle.
REQ-005 ex_mem_rd  in  1  EX instruction is a load (includes stack pop).
REQ-006 ex_mem_wr  in  1  EX instruction is a store (includes stack push).
REQ-007 mem_addr  in  32  byte address from EX (SP or ALU result).
REQ-008 mem_data  in  32  store data from EX.
REQ-009 alu_out  in  32  ALU result for non-memory instructions.
REQ-010 reg_dest_in  in  4  destination register index.
REQ-011 dmem_req  out  1  data-memory request, held until acknowledged.
REQ-012 dmem_we  out  1  1 = write, 0 = read; valid while dmem_req.
REQ-013 dmem_addr  out  32  word-aligned address; stable while dmem_req.
REQ-014 dmem_wdata  out  32  write data; stable while dmem_req.
REQ-015 dmem_ack  in  1  memory completion, one-cycle pulse.
REQ-016 dmem_rdata  in  32  read data, valid in the dmem_ack cycle.
REQ-017 wb_valid  out  1  registered result valid for WB.
REQ-018 wb_data  out  32  load data or forwarded alu_out.
REQ-019 wb_reg_dest  out  4  destination index for WB.
REQ-020 stall  out  1  combinational; upstream holds the EX outputs while high.
REQ-021 err  out  1  one-cycle pulse on a misaligned access, an illegal access, or a timeout.

Function
REQ-022 FSM states: IDLE and BUSY.
REQ-023 IDLE transition:
- Condition: ex_valid=1, exactly one of rd/wr set, and mem_addr[1:0]=00.
- Latch addr, wdata, we and reg_dest_in.
- Go to BUSY; dmem_req=1 from the next cycle.
REQ-024 stall SHALL be 1 when state==BUSY, or when in IDLE with a memory access being accepted this cycle; otherwise stall SHALL be 0.
REQ-025 In BUSY, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL hold constant until dmem_ack is sampled high.
REQ-026 When dmem_ack is sampled high in BUSY:
- Next cycle: dmem_req=0, state=IDLE, wb_valid=1 for one cycle.
- wb_data = dmem_rdata for a read; wb_data = latched wdata for a write.
- wb_reg_dest = the latched destination index.
REQ-027 Minimum memory latency is 2 cycles, accept edge to wb_valid, with ack in the first BUSY cycle.
REQ-028 In IDLE, ex_valid=1 with rd=wr=0 SHALL give wb_valid=1, wb_data=alu_out and wb_reg_dest=reg_dest_in on the next cycle, with no stall.
REQ-029 ex_valid=1 with rd=wr=1, or with a memory access where mem_addr[1:0]!=00:
- No request is issued.
- err pulses on the next cycle.
- wb_valid=0 on the next cycle.
- state remains IDLE.
REQ-030 dmem_ack received in IDLE SHALL be ignored.
REQ-031 ex_valid=0 in IDLE SHALL give wb_valid=0 on the next cycle.

Reset
REQ-032 When rst is sampled high on any edge, including mid-BUSY:
- state=IDLE.
- dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
- wb_valid=0, wb_data=0, wb_reg_dest=0, err=0.
- The timeout count returns to 0.
REQ-033 An ack arriving in the cycle after reset SHALL be ignored.

Configuration
REQ-034 With MEM_TIMEOUT_EN defined:
- A counter runs while in BUSY.
- When it reaches TIMEOUT_CYCLES without an ack: next cycle dmem_req=0, err=1 for one cycle, wb_valid=0, state=IDLE.
- A later ack for the aborted access SHALL be ignored.
REQ-035 Without MEM_TIMEOUT_EN, BUSY SHALL wait for dmem_ack indefinitely, and no counter logic SHALL be present.

Structure
REQ-036 Package mem_pkg SHALL hold:
- the FSM state enum (IDLE, BUSY);
- the default TIMEOUT_CYCLES constant;
- the 32-bit word and 4-bit register-index typedefs.
REQ-037 The timeout counter SHALL be a sub-module mem_watchdog (inputs clk, rst, run, clear; output expired), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-038 The bench SHALL cover the following directed scenarios:
- Load, addr 0x100, ack after 3 BUSY cycles with rdata 0xDEADBEEF -> stall high 4 cycles; wb_valid one cycle later with wb_data 0xDEADBEEF and wb_reg_dest as issued.
- Store, addr 0x200, data 0x12345678, ack in the first BUSY cycle -> dmem_we=1, addr and data stable, wb_valid 2 cycles after accept.
- Non-memory op, alu_out 0x55 -> wb_data 0x55 next cycle, stall=0, dmem_req never rises.
- Load at addr 0x101, and separately rd=wr=1 -> err pulse one cycle, no dmem_req, wb_valid=0.
- rst asserted during BUSY, then ack the following cycle -> dmem_req=0 and all outputs zero; the ack produces no wb_valid.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> after 4 BUSY cycles, err pulse and return to IDLE; a late ack is ignored.
